// File: rtl/estacionamiento_pkg.sv
// Shared constants for the parking display: active-low gfedcba glyphs and digit count.
package estacionamiento_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_I     = 7'b1111001;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_digito(input logic [2:0] n);
    logic [6:0] g;
    case (n)
      3'd0:    g = SEG_0;
      3'd1:    g = SEG_1;
      3'd2:    g = SEG_2;
      3'd3:    g = SEG_3;
      3'd4:    g = SEG_4;
      3'd5:    g = SEG_5;
      3'd6:    g = SEG_6;
      3'd7:    g = SEG_7;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running modulo-DIV counter with enable and synchronous clear; tick marks the terminal count.
module divisor_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt_r;

  // Counter advances only when enabled; clear dominates so a stopped divisor restarts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (en) begin
      if (cnt_r == TERM) cnt_r <= {W{1'b0}};
      else               cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = en & ~clr & (cnt_r == TERM);

endmodule

// File: rtl/display_estacionamiento.sv
// 4-digit multiplexed display of the parking count ("LIb n" / blinking "FUL n") plus entry/exit/full LEDs.
module display_estacionamiento
  import estacionamiento_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000,
  parameter int PULSE_LEN   = 50000000,
  parameter int CAPACIDAD   = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            cantidad,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  led_entrada,
  output logic                  led_salida,
  output logic                  led_lleno
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN - 1);

  logic                  full_s, refresh_tick_s, blink_tick_s, disp_on_s;
  logic                  inc_s, dec_s;
  logic [1:0]            idx_r;
  logic                  phase_r, first_r;
  logic [2:0]            prev_r;
  logic [PW-1:0]         ent_cnt_r, sal_cnt_r;
  logic [6:0]            seg_s;
  logic [NUM_DIGITS-1:0] an_s;

  assign full_s = (cantidad >= 3'(CAPACIDAD));
  // Leaving full shows the display in the very cycle the phase register is forced back on.
  assign disp_on_s = ~full_s | phase_r;
  assign inc_s = ~first_r & (cantidad > prev_r);
  assign dec_s = ~first_r & (cantidad < prev_r);

  divisor_tick #(.DIV(REFRESH_DIV)) u_refresh (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .tick(refresh_tick_s)
  );

  divisor_tick #(.DIV(BLINK_DIV)) u_blink (
    .clk(clk), .reset(reset), .en(full_s), .clr(~full_s), .tick(blink_tick_s)
  );

  // Glyph and digit-enable selection for the current scan index.
  always_comb begin
    seg_s = SEG_BLANK;
    an_s  = 4'b1111;
    if (disp_on_s) begin
      an_s = ~(4'b0001 << idx_r);
      case (idx_r)
        2'd0:    seg_s = seg_digito(cantidad);
        2'd1:    seg_s = full_s ? SEG_L : SEG_B;
        2'd2:    seg_s = full_s ? SEG_U : SEG_I;
        2'd3:    seg_s = full_s ? SEG_F : SEG_L;
        default: seg_s = SEG_BLANK;
      endcase
    end else begin
      seg_s = SEG_BLANK;
      an_s  = 4'b1111;
    end
  end

  // Scan index, blink phase and the registered display/full outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r     <= 2'd0;
      phase_r   <= 1'b1;
      seg       <= SEG_BLANK;
      an        <= 4'b1111;
      led_lleno <= 1'b0;
    end else begin
      idx_r     <= refresh_tick_s ? idx_r + 2'd1 : idx_r;
      if (!full_s)           phase_r <= 1'b1;
      else if (blink_tick_s) phase_r <= ~phase_r;
      else                   phase_r <= phase_r;
      seg       <= seg_s;
      an        <= an_s;
      led_lleno <= full_s;
    end
  end

  // Count-change detection and retriggerable entry/exit pulses; a new direction cancels the other.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_r     <= 1'b1;
      prev_r      <= 3'd0;
      ent_cnt_r   <= {PW{1'b0}};
      sal_cnt_r   <= {PW{1'b0}};
      led_entrada <= 1'b0;
      led_salida  <= 1'b0;
    end else begin
      first_r <= 1'b0;
      prev_r  <= cantidad;
      if (inc_s) begin
        ent_cnt_r   <= PULSE_LOAD;
        led_entrada <= 1'b1;
        sal_cnt_r   <= {PW{1'b0}};
        led_salida  <= 1'b0;
      end else if (dec_s) begin
        sal_cnt_r   <= PULSE_LOAD;
        led_salida  <= 1'b1;
        ent_cnt_r   <= {PW{1'b0}};
        led_entrada <= 1'b0;
      end else begin
        ent_cnt_r   <= (ent_cnt_r != {PW{1'b0}}) ? ent_cnt_r - PW'(1) : ent_cnt_r;
        sal_cnt_r   <= (sal_cnt_r != {PW{1'b0}}) ? sal_cnt_r - PW'(1) : sal_cnt_r;
        led_entrada <= (ent_cnt_r != {PW{1'b0}});
        led_salida  <= (sal_cnt_r != {PW{1'b0}});
      end
    end
  end

endmodule

// File: doc/display_estacionamiento.md
Name: display_estacionamiento

Overview:
Downstream consumer of the parking FSM's 3-bit car count (cantidad). It drives a 4-digit multiplexed common-anode 7-segment display:
- digit 0 shows the count (0-7);
- digits 3..1 show "LIb" (free) or "FUL" (full); the whole display blinks while full.
It also generates timed entry/exit indicator LEDs from count changes.
It sits beside the parking FSM in the top level, in the same clock domain.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays enabled (scan tick period)
BLINK_DIV, 25000000, clock cycles per blink half-period while full
PULSE_LEN, 50000000, clock cycles an entry/exit LED stays lit after a count change
CAPACIDAD, 7, count value treated as full (1..7)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
cantidad  input  3  car count from the FSM, synchronous to clk
seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low
an  output  4  digit enables, active-low, an[0] = rightmost digit
led_entrada  output  1  high for PULSE_LEN cycles after a count increase
led_salida  output  1  high for PULSE_LEN cycles after a count decrease
led_lleno  output  1  high while cantidad >= CAPACIDAD

Behaviour:
- One clock. Reset is asynchronous and active-low: clock port clk, reset port reset, all flops cleared on reset==0 regardless of clk.
- Reset values:
  - seg=7'b1111111, an=4'b1111, led_entrada=0, led_salida=0, led_lleno=0;
  - scan index=0, all counters=0, blink phase=on, first-cycle flag set.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1; the terminal count produces a 1-cycle tick.
  - On each tick, the 2-bit scan index increments and wraps 3->0.
  - seg and an are registered: they reflect the new index on the clock edge after the tick (1-cycle latency).
  - Exactly one an bit is low at a time, except during blank phase or reset.
- Digit content by scan index:
  - 0: decimal glyph of cantidad.
  - 1..3, not full: "b","I","L" (idx1,idx2,idx3), so the display reads "LIb n".
  - 1..3, full: "L","U","F", so the display reads "FUL n".
- Full = unsigned cantidad >= CAPACIDAD, combinational from cantidad. led_lleno is a registered copy (1-cycle latency).
- Blink:
  - The blink counter runs only while full. Each BLINK_DIV cycles it toggles the phase.
  - In the off phase, an=4'b1111 and seg=blank.
  - On leaving full, the blink counter clears and the phase is forced on in the same cycle.
- Change detect:
  - cantidad_prev is registered every cycle.
  - First cycle after reset release: prev <= cantidad, no pulse.
  - Thereafter, cantidad > prev starts the entrada pulse and cantidad < prev starts the salida pulse. Comparison is unsigned 3-bit; no wrap semantics.
  - Starting a pulse loads its down-counter with PULSE_LEN-1. The LED is high while the counter is nonzero or on the load cycle, so it stays high for exactly PULSE_LEN cycles.
  - A new same-direction change reloads (retriggers) the pulse.
  - An opposite-direction change clears the other LED in the same cycle. The two LEDs are never high together.
  - A multi-step change in one cycle counts as one event.
- Reset mid-operation: all outputs return to reset values immediately. No pulse is generated for the count value seen on release.
- Glyph encoding (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000;
  - L=1000111, I=1111001, b=0000011, F=0001110, U=1000001, blank=1111111.

Decomposition:
- Package estacionamiento_pkg: glyph localparams SEG_0..SEG_7, SEG_L, SEG_I, SEG_B, SEG_F, SEG_U, SEG_BLANK; constant NUM_DIGITS=4.
- One sub-module, divisor_tick (parameter DIV; inputs clk, reset, en, clr; output tick). It is instantiated twice: refresh (en=1, clr=0) and blink (en=full, clr=~full).
- Glyph mux, change detect and pulse counters stay in the top block.

Test Plan:
Use REFRESH_DIV=4, BLINK_DIV=16, PULSE_LEN=10, CAPACIDAD=7.
1. Reset low 3 cycles with cantidad=3, then release. Expect seg=1111111, an=1111 during reset. After release, an cycles 1110->1101->1011->0111 every 4 cycles, with seg = SEG_3, SEG_B, SEG_I, SEG_L. No LED pulse.
2. Step cantidad 3->4. Expect led_entrada high exactly 10 cycles and led_salida=0. A second step 4->5 at cycle 6 retriggers, giving 16 total high cycles.
3. Step cantidad 5->4, then 4->5 three cycles later. Expect led_salida high 3 cycles, cleared on the same edge led_entrada rises. Never both high.
4. Set cantidad=7. Expect led_lleno=1 one cycle later and digits 3..1 = F,U,L. After 16 cycles all an=1111 for 16 cycles, then scanning resumes. Drop to 6: phase on immediately, led_lleno=0, "LIb" shown.
5. Assert reset low mid-pulse and during the blank phase. Expect all outputs at reset values within the same cycle (asynchronous). After release with cantidad=6, no led_salida/led_entrada pulse.
6. Jump cantidad 0->5 in one cycle. Expect a single 10-cycle entrada pulse and digit 0 = SEG_5.
